hazard_unit: RTL and testbench

Pipeline control-bundle carrier and hazard controller for the 5-stage RISC-V core. It takes the decoded control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and taken branches, and drives PC/IF-ID write-enable, IF/ID flush and bubble insertion. It sits between instruction decode and the datapath pipeline registers.

---
 rtl/hazard_unit.sv | 185 ++++++++++++++++++
 tb/tb_hazard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Carries the decoded control bundle of the 5-stage RISC-V pipeline through
// the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and
// taken branches, and drives the PC / IF-ID enables, the IF/ID flush and
// bubble insertion into ID/EX.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> saturating stall/flush event counters are built
//   undefined -> no counter registers; stall_cnt / flush_cnt are tied to 0
//
// Ports
//   clk, reset            core clock; synchronous active-high reset
//   id_valid              IF/ID holds a real instruction
//   id_ctrl[7:0]          {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//                          ALUOp[1], ALUOp[0], Branch}
//   id_rs1/rs2/rd         register fields of the instruction in ID
//   id_uses_rs1/rs2       instruction in ID actually reads that source
//   ex_branch_taken       EX comparator result (only meaningful for Branch)
//   ex_ctrl, mem_ctrl     registered bundles in EX and MEM
//   ex_rd, mem_rd, wb_rd  registered destination indices
//   wb_regwrite/memtoreg  registered WB controls
//   pc_write, ifid_write  PC and IF/ID enables (combinational)
//   ifid_flush            IF/ID loads a NOP at the next edge (combinational)
//   hz_state              last-cycle event: 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt  event counters
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [7:0]       id_ctrl,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_branch_taken,
  output logic [7:0]       ex_ctrl,
  output logic [7:0]       mem_ctrl,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10,
    HZ_RSVD  = 2'b11
  } hz_state_e;

  // Pipeline control registers
  logic [7:0]       ex_ctrl_q,  ex_ctrl_d;
  logic [7:0]       mem_ctrl_q;
  logic [REG_W-1:0] ex_rd_q;
  logic [REG_W-1:0] mem_rd_q;
  logic [REG_W-1:0] wb_rd_q;
  logic             wb_regwrite_q;
  logic             wb_memtoreg_q;
  hz_state_e        hz_state_q, hz_state_d;

  logic load_use;
  logic br;

  // Hazard detection. A taken branch squashes the instruction in ID, so any
  // load-use stall it would have caused is discarded.
  always_comb begin
    load_use = ex_ctrl_q[4] && (ex_rd_q != '0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd_q)));
    br       = ex_ctrl_q[0] && ex_branch_taken;
  end

  // Front-end enables and next ID/EX bundle; reset holds the front end and
  // forces a NOP into IF/ID.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ex_ctrl_d  = id_valid ? id_ctrl : 8'h00;
    hz_state_d = HZ_RUN;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      ex_ctrl_d  = 8'h00;
      hz_state_d = HZ_RUN;
    end else if (br) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      ex_ctrl_d  = 8'h00;
      hz_state_d = HZ_FLUSH;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      ex_ctrl_d  = 8'h00;
      hz_state_d = HZ_STALL;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      hz_state_d = HZ_RUN;
    end
  end

  // Pipeline control registers and event state. The next state is derived
  // from this cycle's events only, so a stray reserved code lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q     <= 8'h00;
      mem_ctrl_q    <= 8'h00;
      ex_rd_q       <= '0;
      mem_rd_q      <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      hz_state_q    <= HZ_RUN;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      // rd follows ID even on a bubble; the zero bundle makes it inert.
      ex_rd_q       <= id_rd;
      mem_ctrl_q    <= ex_ctrl_q;
      mem_rd_q      <= ex_rd_q;
      wb_regwrite_q <= mem_ctrl_q[5];
      wb_memtoreg_q <= mem_ctrl_q[6];
      wb_rd_q       <= mem_rd_q;
      hz_state_q    <= hz_state_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters; a stall overridden by a branch is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use && !br && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (br && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign ex_rd       = ex_rd_q;
  assign mem_rd      = mem_rd_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_memtoreg = wb_memtoreg_q;
  assign hz_state    = hz_state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed, table-driven bench for hazard_unit (CNT_W = 4 so saturation is
// reachable). A vector table exercises hazard detection cycle by cycle; hand
// sequences cover propagation latency, reset during a stall and counter
// saturation. Counter expectations follow HAZARD_STATS_EN.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [7:0]       id_ctrl;
  logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_branch_taken;
  logic [7:0]       ex_ctrl, mem_ctrl;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             wb_regwrite, wb_memtoreg;
  logic             pc_write, ifid_write, ifid_flush;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_branch_taken(ex_branch_taken),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .hz_state(hz_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] ctrl;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, bt;
    logic       pcw, ifw, fl;   // expected combinational outputs before the edge
    logic [7:0] ex;             // expected ex_ctrl after the edge
    logic [1:0] hz;             // expected hz_state after the edge
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic rst, logic vld, logic [7:0] ctrl,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic u1, logic u2, logic bt,
                              logic pcw, logic ifw, logic fl,
                              logic [7:0] ex, logic [1:0] hz);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ctrl = ctrl;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.bt = bt;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.ex = ex; v.hz = hz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [7:0] ctrl,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic bt);
    reset = rst; id_valid = vld; id_ctrl = ctrl;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; ex_branch_taken = bt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    //           rst  vld  ctrl   rs1 rs2 rd  u1 u2 bt  pcw ifw fl  ex     hz
    tbl[0]  = mk(1'b1,1'b0,8'h00, 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 8'h00,2'b00);
    tbl[1]  = mk(1'b0,1'b1,8'hF0, 5'd1,5'd0,5'd5, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hF0,2'b00); // lw x5
    tbl[2]  = mk(1'b0,1'b1,8'h20, 5'd5,5'd1,5'd6, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 8'h00,2'b01); // add x6,x5,x1 stalls
    tbl[3]  = mk(1'b0,1'b1,8'h20, 5'd5,5'd1,5'd6, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'h20,2'b00); // add proceeds
    tbl[4]  = mk(1'b0,1'b1,8'hF0, 5'd1,5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hF0,2'b00); // lw x0
    tbl[5]  = mk(1'b0,1'b1,8'h20, 5'd0,5'd0,5'd6, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'h20,2'b00); // reads x0: no stall
    tbl[6]  = mk(1'b0,1'b1,8'hF0, 5'd1,5'd0,5'd5, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hF0,2'b00); // lw x5
    tbl[7]  = mk(1'b0,1'b1,8'hA6, 5'd5,5'd5,5'd5, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hA6,2'b00); // lui x5: no stall
    tbl[8]  = mk(1'b0,1'b1,8'h03, 5'd1,5'd2,5'd0, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'h03,2'b00); // beq enters EX
    tbl[9]  = mk(1'b0,1'b1,8'h20, 5'd3,5'd0,5'd9, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1, 8'h00,2'b10); // taken: flush
    tbl[10] = mk(1'b0,1'b0,8'hFF, 5'd0,5'd0,5'd2, 1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'h00,2'b00); // invalid ID
    tbl[11] = mk(1'b0,1'b1,8'h13, 5'd1,5'd0,5'd4, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'h13,2'b00); // load+branch bundle
    tbl[12] = mk(1'b0,1'b1,8'h20, 5'd4,5'd0,5'd8, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1, 8'h00,2'b10); // br beats load-use
    tbl[13] = mk(1'b0,1'b1,8'h03, 5'd1,5'd2,5'd0, 1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 8'h03,2'b00);
    tbl[14] = mk(1'b0,1'b1,8'h20, 5'd1,5'd0,5'd3, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'h20,2'b00); // not taken
    tbl[15] = mk(1'b0,1'b1,8'hA6, 5'd3,5'd0,5'd7, 1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0, 8'hA6,2'b00); // taken w/o Branch
    tbl[16] = mk(1'b0,1'b1,8'hF0, 5'd1,5'd0,5'd5, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hF0,2'b00); // lw x5
    tbl[17] = mk(1'b0,1'b1,8'hF0, 5'd5,5'd0,5'd6, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'h00,2'b01); // lw x6,0(x5) stalls
    tbl[18] = mk(1'b0,1'b1,8'hF0, 5'd5,5'd0,5'd6, 1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 8'hF0,2'b00); // once only
    tbl[19] = mk(1'b0,1'b1,8'h20, 5'd6,5'd0,5'd7, 1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'h00,2'b01); // uses x6: stall

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].vld, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].u1, tbl[i].u2, tbl[i].bt);
      #1;
      chk($sformatf("v%0d pc_write", i),   {31'd0, pc_write},   {31'd0, tbl[i].pcw});
      chk($sformatf("v%0d ifid_write", i), {31'd0, ifid_write}, {31'd0, tbl[i].ifw});
      chk($sformatf("v%0d ifid_flush", i), {31'd0, ifid_flush}, {31'd0, tbl[i].fl});
      tick();
      chk($sformatf("v%0d ex_ctrl", i),  {24'd0, ex_ctrl},  {24'd0, tbl[i].ex});
      chk($sformatf("v%0d hz_state", i), {30'd0, hz_state}, {30'd0, tbl[i].hz});
    end
    // stalls at v2, v17, v19; flushes at v9, v12
    chk("table stall_cnt", {28'd0, stall_cnt}, STATS ? 32'd3 : 32'd0);
    chk("table flush_cnt", {28'd0, flush_cnt}, STATS ? 32'd2 : 32'd0);

    // Propagation: bundle in ID at edge N -> EX after N, MEM after N+1, WB after N+2
    @(negedge clk); drive(1'b1, 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reset ex_ctrl",     {24'd0, ex_ctrl},   32'd0);
    chk("reset hz_state",    {30'd0, hz_state},  32'd0);
    chk("reset stall_cnt",   {28'd0, stall_cnt}, 32'd0);
    chk("reset flush_cnt",   {28'd0, flush_cnt}, 32'd0);
    @(negedge clk); drive(1'b0, 1'b1, 8'hA6, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    chk("prop ex_ctrl", {24'd0, ex_ctrl}, 32'hA6);
    chk("prop ex_rd",   {27'd0, ex_rd},   32'd7);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("prop mem_ctrl",   {24'd0, mem_ctrl}, 32'hA6);
    chk("prop mem_rd",     {27'd0, mem_rd},   32'd7);
    chk("prop wb_regwrite early", {31'd0, wb_regwrite}, 32'd0);
    tick();
    chk("prop wb_regwrite", {31'd0, wb_regwrite}, 32'd1);
    chk("prop wb_memtoreg", {31'd0, wb_memtoreg}, 32'd0);
    chk("prop wb_rd",       {27'd0, wb_rd},       32'd7);
    tick();
    chk("prop wb_regwrite drains", {31'd0, wb_regwrite}, 32'd0);

    // Reset asserted during a load-use stall
    @(negedge clk); drive(1'b0, 1'b1, 8'hF0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    @(negedge clk); drive(1'b0, 1'b1, 8'h20, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst-stall pc_write pre", {31'd0, pc_write}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst-stall pc_write",   {31'd0, pc_write},   32'd0);
    chk("rst-stall ifid_write", {31'd0, ifid_write}, 32'd0);
    chk("rst-stall ifid_flush", {31'd0, ifid_flush}, 32'd1);
    tick();
    chk("rst-stall ex_ctrl",   {24'd0, ex_ctrl},   32'd0);
    chk("rst-stall mem_ctrl",  {24'd0, mem_ctrl},  32'd0);
    chk("rst-stall ex_rd",     {27'd0, ex_rd},     32'd0);
    chk("rst-stall mem_rd",    {27'd0, mem_rd},    32'd0);
    chk("rst-stall hz_state",  {30'd0, hz_state},  32'd0);
    chk("rst-stall stall_cnt", {28'd0, stall_cnt}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("post-reset pc_write", {31'd0, pc_write}, 32'd1);

    // Saturation: 20 load-use events on a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); drive(1'b0, 1'b1, 8'hF0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      @(negedge clk); drive(1'b0, 1'b1, 8'h20, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      tick();
      if (k == 2) chk("sat stall_cnt after 3", {28'd0, stall_cnt}, STATS ? 32'd3 : 32'd0);
    end
    chk("sat stall_cnt", {28'd0, stall_cnt}, STATS ? 32'd15 : 32'd0);
    chk("sat flush_cnt", {28'd0, flush_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
